wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: entries per source queue; power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 3: consecutive cycles a waiting ALU head may lose before it is forced to win.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 alu_valid  input  1 / alu_ready  output  1 / alu_wa  input  4 / alu_wd  input  8: ALU result channel.
REQ-006 mem_valid  input  1 / mem_ready  output  1 / mem_wa  input  4 / mem_wd  input  8: load-result channel.
REQ-007 we  output  1 / wa  output  4 / wd  output  8: single register-file write port, registered.
REQ-008 chk_ra  input  4 / chk_rb  input  4 / hazard_a  output  1 / hazard_b  output  1: pending-write query for decode.

Function
REQ-009 Transfer on a channel SHALL occur when valid and ready are both high at a rising edge.
REQ-010 ready SHALL be high exactly when that source queue holds fewer than DEPTH entries, decoded from registered state only, never from valid.
REQ-011 Accepted writes with wa == 0 SHALL be consumed and discarded: not enqueued, never reach the port.
REQ-012 Each source SHALL have an in-order FIFO of {wa, wd}; order within a source SHALL be preserved.
REQ-013 Each cycle, at most one queue head SHALL be popped; the popped entry SHALL appear on we/wa/wd at the next edge (1-cycle latency, queue head to port).
REQ-014 Arbitration: mem head wins over alu head, unless starve count == STARVE_LIMIT, in which case alu wins.
REQ-015 Starve count: increments when the alu head is present and loses; clears when alu pops or alu queue is empty; saturates at STARVE_LIMIT.
REQ-016 With one queue non-empty, that queue SHALL pop every cycle; with both empty, we SHALL be 0 next cycle and wa/wd hold.
REQ-017 Push and pop on the same queue in the same cycle SHALL both take effect; count unchanged.
REQ-018 An entry accepted at edge N SHALL be eligible for arbitration at edge N+1 (no input-to-output bypass).
REQ-019 hazard_a SHALL be high when chk_ra != 0 and chk_ra matches the wa of any valid entry in either queue, or of the output register while we = 1; hazard_b likewise for chk_rb.
REQ-020 hazard outputs SHALL be combinational from chk_* and registered state only.
REQ-021 Same-register writes from both sources SHALL reach the port in arbitration order; no merging or cancellation.

Reset
REQ-022 While rst is high at an edge: both queues empty, starve count 0, we = 0, wa = 0, wd = 0.
REQ-023 Entries in flight at reset SHALL be dropped; no write SHALL issue in the cycle after reset.
REQ-024 During and immediately after reset: alu_ready = mem_ready = 1, hazard_a = hazard_b = 0.

Structure
REQ-025 Shared package SHALL hold REG_ADDR_W = 4, REG_DATA_W = 8, and the {wa, wd} write-entry typedef used by the register file and this block.
REQ-026 One sub-module, wb_fifo (DEPTH-parameterised sync FIFO exposing count and per-entry wa for hazard compare), SHALL be instantiated twice.

Verification
REQ-027 Single write: alu pushes (wa = 3, wd = 0x5A) at edge 0 -> edge 2: we = 1, wa = 3, wd = 0x5A; then we = 0.
REQ-028 r0 drop: mem pushes (wa = 0, wd = 0xFF) -> mem_ready stays 1, we never asserts, hazard_a with chk_ra = 0 stays 0.
REQ-029 Priority and starvation: alu holds 1 entry (wa = 1), mem streams continuously -> exactly 3 mem writes, then the alu write, then mem resumes.
REQ-030 Backpressure: fill the alu queue with 2 entries while mem is busy -> alu_ready = 0 the following cycle; a valid held under ready = 0 is not lost and is written later, in order.
REQ-031 Hazard: alu pushes wa = 7 -> hazard_a = 1 for chk_ra = 7 until the cycle after we/wa = 7 is presented, 0 thereafter; chk_rb = 6 gives 0 throughout.
REQ-032 Reset mid-operation: both queues full, assert rst for 1 cycle -> next cycle we = 0, both ready = 1, no stale write ever issues.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared register-file write types for the writeback path.
// The write entry is common to the register file and the writeback arbiter.
package wb_arbiter_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 8;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   typedef struct packed {
      reg_addr_t wa;
      reg_data_t wd;
   } wr_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_ALU,
      SEL_MEM
   } wb_sel_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bundle: ALU and load-result channels, register-file write port,
// and the pending-write query used by decode.
interface wb_arbiter_if;
   import wb_arbiter_pkg::*;

   logic      alu_valid;
   logic      alu_ready;
   reg_addr_t alu_wa;
   reg_data_t alu_wd;

   logic      mem_valid;
   logic      mem_ready;
   reg_addr_t mem_wa;
   reg_data_t mem_wd;

   logic      we;
   reg_addr_t wa;
   reg_data_t wd;

   reg_addr_t chk_ra;
   reg_addr_t chk_rb;
   logic      hazard_a;
   logic      hazard_b;

   modport slave (
      input  alu_valid, alu_wa, alu_wd,
      input  mem_valid, mem_wa, mem_wd,
      input  chk_ra, chk_rb,
      output alu_ready, mem_ready,
      output we, wa, wd,
      output hazard_a, hazard_b
   );

   modport master (
      output alu_valid, alu_wa, alu_wd,
      output mem_valid, mem_wa, mem_wd,
      output chk_ra, chk_rb,
      input  alu_ready, mem_ready,
      input  we, wa, wd,
      input  hazard_a, hazard_b
   );

endinterface

// File: rtl/wb_fifo.sv
// In-order write-entry FIFO; exposes occupancy and every slot's address with
// a live mask so the owner can search pending writes.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wr_entry_t              push_data,
   input  logic                   pop,
   output wr_entry_t              head,
   output logic [$clog2(DEPTH):0] count,
   output reg_addr_t              entry_wa [DEPTH],
   output logic [DEPTH-1:0]       entry_vld
);

   localparam int AW = $clog2(DEPTH);

   wr_entry_t     slots [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] off;

   // NOTE: storage has no reset; count alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push) slots[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = slots[rd_ptr];

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      entry_vld = '0;
      off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off          = AW'(i) - rd_ptr;
         entry_vld[i] = ({1'b0, off} < count);
         entry_wa[i]  = slots[i].wa;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Two-source register-file writeback arbiter: load results win over ALU
// results, with a starvation cap that forces a waiting ALU head through.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   wb_arbiter_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0]    alu_count, mem_count;
   wr_entry_t        alu_head, mem_head;
   reg_addr_t        alu_ewa [DEPTH];
   reg_addr_t        mem_ewa [DEPTH];
   logic [DEPTH-1:0] alu_evld, mem_evld;
   logic             alu_push, mem_push, alu_pop, mem_pop;
   logic             alu_has, mem_has;
   logic [SW-1:0]    starve_cnt, starve_nxt;
   wb_sel_t          sel;
   logic             we_q;
   wr_entry_t        out_q;
   logic             haz_a, haz_b;

   // Ready depends only on occupancy, never on valid or on this cycle's pop.
   assign bus.alu_ready = (alu_count < CW'(DEPTH));
   assign bus.mem_ready = (mem_count < CW'(DEPTH));

   // Writes to r0 complete the handshake but are never stored.
   assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_wa != '0);
   assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_wa != '0);

   assign alu_has = (alu_count != '0);
   assign mem_has = (mem_count != '0);
   assign alu_pop = (sel == SEL_ALU);
   assign mem_pop = (sel == SEL_MEM);

   wb_fifo #(.DEPTH(DEPTH)) u_alu_q (
      .clk       (clk),
      .rst       (rst),
      .push      (alu_push),
      .push_data ('{wa: bus.alu_wa, wd: bus.alu_wd}),
      .pop       (alu_pop),
      .head      (alu_head),
      .count     (alu_count),
      .entry_wa  (alu_ewa),
      .entry_vld (alu_evld)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_mem_q (
      .clk       (clk),
      .rst       (rst),
      .push      (mem_push),
      .push_data ('{wa: bus.mem_wa, wd: bus.mem_wd}),
      .pop       (mem_pop),
      .head      (mem_head),
      .count     (mem_count),
      .entry_wa  (mem_ewa),
      .entry_vld (mem_evld)
   );

   always_comb begin
      // NOTE: combinational logic uses blocking '='; clocked state uses '<='.
      sel        = SEL_NONE;
      starve_nxt = starve_cnt;
      if (mem_has && !(alu_has && starve_cnt == SW'(STARVE_LIMIT))) sel = SEL_MEM;
      else if (alu_has)                                              sel = SEL_ALU;

      if (!alu_has || sel == SEL_ALU)            starve_nxt = '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))  starve_nxt = starve_cnt + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         we_q       <= 1'b0;
         out_q      <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         we_q       <= (sel != SEL_NONE);
         if (sel == SEL_ALU)      out_q <= alu_head;
         else if (sel == SEL_MEM) out_q <= mem_head;
      end
   end

   assign bus.we = we_q;
   assign bus.wa = out_q.wa;
   assign bus.wd = out_q.wd;

   // Pending-write search over both queues and the write port; r0 never hazards.
   always_comb begin
      haz_a = 1'b0;
      haz_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_evld[i] && alu_ewa[i] == bus.chk_ra) haz_a = 1'b1;
         if (mem_evld[i] && mem_ewa[i] == bus.chk_ra) haz_a = 1'b1;
         if (alu_evld[i] && alu_ewa[i] == bus.chk_rb) haz_b = 1'b1;
         if (mem_evld[i] && mem_ewa[i] == bus.chk_rb) haz_b = 1'b1;
      end
      if (we_q && out_q.wa == bus.chk_ra) haz_a = 1'b1;
      if (we_q && out_q.wa == bus.chk_rb) haz_b = 1'b1;
      if (bus.chk_ra == '0) haz_a = 1'b0;
      if (bus.chk_rb == '0) haz_b = 1'b0;
   end

   assign bus.hazard_a = haz_a;
   assign bus.hazard_b = haz_b;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single write, r0 drop, priority and
// starvation, backpressure, hazard query, same-register ordering, mid-run reset.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [3:0] exp_wa [6];
   logic [7:0] exp_wd [6];
   logic       r;
   int         k;

   wb_arbiter_if bus ();

   wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_alu(input logic v, input logic [3:0] wa, input logic [7:0] wd);
      bus.alu_valid = v;
      bus.alu_wa    = wa;
      bus.alu_wd    = wd;
   endtask

   task automatic drive_mem(input logic v, input logic [3:0] wa, input logic [7:0] wd);
      bus.mem_valid = v;
      bus.mem_wa    = wa;
      bus.mem_wd    = wd;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [3:0] wa, input logic [7:0] wd);
      check({tag, ".we"}, 32'(bus.we), 32'(we));
      if (we) begin
         check({tag, ".wa"}, 32'(bus.wa), 32'(wa));
         check({tag, ".wd"}, 32'(bus.wd), 32'(wd));
      end
   endtask

   initial begin
      exp_wa = '{4'd8, 4'd9, 4'd10, 4'd1, 4'd11, 4'd12};
      exp_wd = '{8'h40, 8'h41, 8'h42, 8'hA1, 8'h43, 8'h44};

      rst = 1'b1;
      drive_alu(1'b0, 4'd0, 8'h00);
      drive_mem(1'b0, 4'd0, 8'h00);
      bus.chk_ra = 4'd3;
      bus.chk_rb = 4'd6;
      tick();
      tick();
      check("rst.we", 32'(bus.we), 0);
      check("rst.wa", 32'(bus.wa), 0);
      check("rst.wd", 32'(bus.wd), 0);
      check("rst.alu_ready", 32'(bus.alu_ready), 1);
      check("rst.mem_ready", 32'(bus.mem_ready), 1);
      check("rst.hazard_a", 32'(bus.hazard_a), 0);
      check("rst.hazard_b", 32'(bus.hazard_b), 0);
      rst = 1'b0;
      tick();

      // Single write: valid driven after edge 0, port shows it after edge 2.
      drive_alu(1'b1, 4'd3, 8'h5A);
      tick();
      drive_alu(1'b0, 4'd0, 8'h00);
      chk_wr("single.e1", 1'b0, 4'd0, 8'h00);
      tick();
      chk_wr("single.e2", 1'b1, 4'd3, 8'h5A);
      tick();
      chk_wr("single.e3", 1'b0, 4'd0, 8'h00);
      check("single.hold_wa", 32'(bus.wa), 3);
      check("single.hold_wd", 32'(bus.wd), 'h5A);

      // r0 drop.
      bus.chk_ra = 4'd0;
      drive_mem(1'b1, 4'd0, 8'hFF);
      tick();
      drive_mem(1'b0, 4'd0, 8'h00);
      check("r0.mem_ready", 32'(bus.mem_ready), 1);
      check("r0.hazard_a", 32'(bus.hazard_a), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("r0.we", 32'(bus.we), 0);
         check("r0.hazard_a_idle", 32'(bus.hazard_a), 0);
      end

      // Priority and starvation: alu holds one entry while mem streams.
      k = 0;
      drive_alu(1'b1, 4'd1, 8'hA1);
      drive_mem(1'b1, 4'(8 + k), 8'(8'h40 + k));
      tick();
      drive_alu(1'b0, 4'd0, 8'h00);
      check("starve.e1_we", 32'(bus.we), 0);
      k = 1;
      drive_mem(1'b1, 4'(8 + k), 8'(8'h40 + k));
      for (int c = 0; c < 6; c++) begin
         r = bus.mem_ready;
         tick();
         if (r) begin
            k++;
            drive_mem(1'b1, 4'(8 + k), 8'(8'h40 + k));
         end
         chk_wr($sformatf("starve.w%0d", c), 1'b1, exp_wa[c], exp_wd[c]);
      end
      drive_mem(1'b0, 4'd0, 8'h00);
      tick();
      chk_wr("starve.tail", 1'b1, 4'd13, 8'h45);
      tick();
      chk_wr("starve.idle", 1'b0, 4'd0, 8'h00);

      // Backpressure: alu fills while mem holds priority.
      drive_alu(1'b1, 4'd2, 8'hB2);
      drive_mem(1'b1, 4'd5, 8'hC5);
      tick();
      drive_alu(1'b1, 4'd3, 8'hB3);
      drive_mem(1'b1, 4'd6, 8'hC6);
      tick();
      chk_wr("bp.m0", 1'b1, 4'd5, 8'hC5);
      check("bp.ready_e2", 32'(bus.alu_ready), 0);
      drive_alu(1'b1, 4'd4, 8'hB4);
      drive_mem(1'b0, 4'd0, 8'h00);
      tick();
      chk_wr("bp.m1", 1'b1, 4'd6, 8'hC6);
      check("bp.ready_e3", 32'(bus.alu_ready), 0);
      tick();
      chk_wr("bp.a", 1'b1, 4'd2, 8'hB2);
      check("bp.ready_e4", 32'(bus.alu_ready), 1);
      tick();
      drive_alu(1'b0, 4'd0, 8'h00);
      chk_wr("bp.b", 1'b1, 4'd3, 8'hB3);
      tick();
      chk_wr("bp.c", 1'b1, 4'd4, 8'hB4);
      tick();
      chk_wr("bp.idle", 1'b0, 4'd0, 8'h00);

      // Hazard lifetime for r7; r6 never pending. Valid alone must not raise it.
      bus.chk_ra = 4'd7;
      bus.chk_rb = 4'd6;
      drive_alu(1'b1, 4'd7, 8'h77);
      #1;
      check("haz.pre", 32'(bus.hazard_a), 0);
      tick();
      drive_alu(1'b0, 4'd0, 8'h00);
      check("haz.queued_a", 32'(bus.hazard_a), 1);
      check("haz.queued_b", 32'(bus.hazard_b), 0);
      tick();
      chk_wr("haz.port", 1'b1, 4'd7, 8'h77);
      check("haz.port_a", 32'(bus.hazard_a), 1);
      check("haz.port_b", 32'(bus.hazard_b), 0);
      tick();
      check("haz.done_a", 32'(bus.hazard_a), 0);
      check("haz.done_b", 32'(bus.hazard_b), 0);

      // Same register from both sources: mem first, then alu, both issued.
      bus.chk_rb = 4'd9;
      drive_alu(1'b1, 4'd9, 8'h01);
      drive_mem(1'b1, 4'd9, 8'h02);
      tick();
      drive_alu(1'b0, 4'd0, 8'h00);
      drive_mem(1'b0, 4'd0, 8'h00);
      check("same.haz_b", 32'(bus.hazard_b), 1);
      tick();
      chk_wr("same.mem", 1'b1, 4'd9, 8'h02);
      tick();
      chk_wr("same.alu", 1'b1, 4'd9, 8'h01);
      tick();
      chk_wr("same.idle", 1'b0, 4'd0, 8'h00);
      check("same.haz_clear", 32'(bus.hazard_b), 0);

      // Reset mid-operation with entries pending in both queues.
      bus.chk_ra = 4'd5;
      bus.chk_rb = 4'd6;
      drive_alu(1'b1, 4'd5, 8'hD5);
      drive_mem(1'b1, 4'd6, 8'hE6);
      for (int i = 0; i < 3; i++) tick();
      check("mrst.pre_haz", 32'(bus.hazard_a), 1);
      rst = 1'b1;
      drive_alu(1'b0, 4'd0, 8'h00);
      drive_mem(1'b0, 4'd0, 8'h00);
      tick();
      rst = 1'b0;
      check("mrst.we", 32'(bus.we), 0);
      check("mrst.wa", 32'(bus.wa), 0);
      check("mrst.wd", 32'(bus.wd), 0);
      check("mrst.alu_ready", 32'(bus.alu_ready), 1);
      check("mrst.mem_ready", 32'(bus.mem_ready), 1);
      check("mrst.hazard_a", 32'(bus.hazard_a), 0);
      check("mrst.hazard_b", 32'(bus.hazard_b), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mrst.no_stale", 32'(bus.we), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
